uart_rx_core: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 30 +++
 rtl/uart_rx_fifo.sv | 51 +++++
 rtl/uart_rx_core.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Optional receive FIFO is selected with the UART_RX_FIFO_EN macro.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int MAX_DATA_BITS = 9;

    // Data is sized for the widest frame; narrower words use the low bits.
    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic                     parity_err;
        logic                     frame_err;
    } rx_entry_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received words; used when UART_RX_FIFO_EN is defined.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             wr_en;
    logic             rd_en;

    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // A pop frees the head slot in the same edge, so a push into a full FIFO is legal then.
    assign wr_en    = push && (!full || pop);
    assign rd_en    = pop && !empty;
    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver with majority-vote sampling and valid/ready output.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);
    localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int BW   = $clog2(DATA_BITS);
    localparam int EW   = DATA_BITS + 2;
    localparam bit CFG_OK = (CPB >= 8) && (DATA_BITS >= 5) && (DATA_BITS <= MAX_DATA_BITS) &&
                            (PARITY_MODE >= PAR_NONE) && (PARITY_MODE <= PAR_EVEN) &&
                            (STOP_BITS >= 1) && (STOP_BITS <= 2) &&
                            (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

    if (!CFG_OK) begin : g_cfg_check
        $error("uart_rx_core: illegal parameter combination");
    end

    rx_state_t            state_reg, state_next;
    logic                 rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [CW-1:0]        cnt_reg;
    logic [BW-1:0]        bit_reg;
    logic                 stop_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err_reg, frm_err_reg;
    logic                 samp_lo_reg, samp_mid_reg;
    logic                 start_edge, decide, maj, stop_last, push, pop, full, empty;
    logic [EW-1:0]        push_word, head_word;

    assign start_edge = rx_prev_reg && !rx_sync_reg;
    assign decide     = (state_reg != ST_IDLE) && (cnt_reg == CW'(HALF + 1));
    assign maj        = (samp_lo_reg & samp_mid_reg) | (samp_lo_reg & rx_sync_reg) |
                        (samp_mid_reg & rx_sync_reg);
    assign stop_last  = (stop_reg == 1'(STOP_BITS - 1));
    // The final stop bit is folded into frame_err here since its register update lands too late.
    assign push_word  = {shift_reg, par_err_reg, frm_err_reg | ~maj};
    assign rx_busy    = (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rx_en && start_edge) state_next = ST_START;
            end
            ST_START: begin
                if (decide) state_next = maj ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (decide && (bit_reg == BW'(DATA_BITS - 1))) begin
                    state_next = (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (decide) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (decide && stop_last) begin
                    push       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            stop_reg     <= 1'b0;
            shift_reg    <= '0;
            par_err_reg  <= 1'b0;
            frm_err_reg  <= 1'b0;
            samp_lo_reg  <= 1'b1;
            samp_mid_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            if (state_reg == ST_IDLE || cnt_reg == CW'(CPB - 1)) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (cnt_reg == CW'(HALF - 1)) samp_lo_reg  <= rx_sync_reg;
            if (cnt_reg == CW'(HALF))     samp_mid_reg <= rx_sync_reg;
            if (decide) begin
                case (state_reg)
                    ST_START: begin
                        bit_reg     <= '0;
                        stop_reg    <= 1'b0;
                        par_err_reg <= 1'b0;
                        frm_err_reg <= 1'b0;
                    end
                    ST_DATA: begin
                        shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
                        bit_reg   <= bit_reg + 1'b1;
                    end
                    ST_PARITY: begin
                        par_err_reg <= (PARITY_MODE == PAR_ODD) ? ~(^shift_reg ^ maj)
                                                                : (^shift_reg ^ maj);
                    end
                    ST_STOP: begin
                        if (!maj) frm_err_reg <= 1'b1;
                        stop_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign pop     = !empty && rx_ready;
    assign overrun = push && full && !pop;

`ifdef UART_RX_FIFO_EN
    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_word),
        .full      (full),
        .empty     (empty)
    );
`else
    logic [EW-1:0] hold_reg;
    logic          hold_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
        end else if (push && (!hold_valid_reg || pop)) begin
            hold_reg       <= push_word;
            hold_valid_reg <= 1'b1;
        end else if (pop) begin
            hold_valid_reg <= 1'b0;
        end
    end

    assign head_word = hold_reg;
    assign full      = hold_valid_reg;
    assign empty     = !hold_valid_reg;
`endif

    // Outputs read as zero when nothing is presented, covering stale storage after reset.
    assign rx_valid   = !empty;
    assign rx_data    = rx_valid ? head_word[EW-1:2] : '0;
    assign parity_err = rx_valid & head_word[1];
    assign frame_err  = rx_valid & head_word[0];

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench: an 8N1 receiver and an 8E2 receiver driven with randomized frames.
module tb_uart_rx_core;
    import uart_rx_pkg::*;

`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CPB = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx_en, rx_a, rx_b, ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
    logic       ovr_a, ovr_b, busy_a, busy_b;

    int vectors = 0;
    int miscompares = 0;
    int exp_ovr_a = 0;
    int seen_ovr_a = 0;
    int seen_ovr_b = 0;
    rx_entry_t q_a[$];
    rx_entry_t q_b[$];

    uart_rx_core #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx(rx_a), .rx_data(data_a),
        .rx_valid(valid_a), .rx_ready(ready_a), .parity_err(perr_a),
        .frame_err(ferr_a), .overrun(ovr_a), .rx_busy(busy_a));

    uart_rx_core #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
                   .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx(rx_b), .rx_data(data_b),
        .rx_valid(valid_b), .rx_ready(ready_b), .parity_err(perr_b),
        .frame_err(ferr_b), .overrun(ovr_b), .rx_busy(busy_b));

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Storage model: a frame is kept while there is room, otherwise it is an overrun.
    task automatic model_push(input int dut, input rx_entry_t e);
        if (dut == 0) begin
            if (!ready_a && q_a.size() >= DEPTH) exp_ovr_a++;
            else q_a.push_back(e);
        end else begin
            q_b.push_back(e);
        end
    endtask

    task automatic pop_cmp(input int dut, input logic [7:0] d, input logic p, input logic f);
        rx_entry_t e;
        int sz;
        sz = (dut == 0) ? q_a.size() : q_b.size();
        $display("rx dut%0d data=%02h perr=%0b ferr=%0b", dut, d, p, f);
        if (sz == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word_dut%0d: actual %02h required none", dut, d);
        end else begin
            if (dut == 0) e = q_a.pop_front();
            else e = q_b.pop_front();
            check($sformatf("word_dut%0d", dut), int'({d, p, f}),
                  int'({e.data[7:0], e.parity_err, e.frame_err}));
        end
    endtask

    bit        hold_a = 1'b0, hold_b = 1'b0;
    logic [9:0] last_a, last_b;

    always @(negedge clk) begin
        if (rst) begin
            hold_a = 1'b0;
            hold_b = 1'b0;
        end else begin
            if (hold_a) check("hold_stable_a", int'({valid_a, data_a, perr_a, ferr_a}), int'({1'b1, last_a}));
            if (hold_b) check("hold_stable_b", int'({valid_b, data_b, perr_b, ferr_b}), int'({1'b1, last_b}));
            if (valid_a && ready_a) pop_cmp(0, data_a, perr_a, ferr_a);
            if (valid_b && ready_b) pop_cmp(1, data_b, perr_b, ferr_b);
            if (ovr_a) seen_ovr_a++;
            if (ovr_b) seen_ovr_b++;
            hold_a = valid_a && !ready_a;
            hold_b = valid_b && !ready_b;
            last_a = {data_a, perr_a, ferr_a};
            last_b = {data_b, perr_b, ferr_b};
        end
    end

    // Frame on the line: start, 8 data bits LSB first, even parity (dut 1), stop bit(s).
    task automatic send_frame(input int dut, input logic [7:0] d, input bit bad_par,
                              input bit bad_stop, input bit expect_it);
        logic      bits[$];
        rx_entry_t e;
        int        nstop;
        int        bad_idx;
        nstop   = (dut == 0) ? 1 : 2;
        bad_idx = $urandom_range(nstop - 1, 0);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (dut == 1) bits.push_back((^d) ^ bad_par);
        for (int i = 0; i < nstop; i++) bits.push_back(!(bad_stop && i == bad_idx));
        e.data       = {1'b0, d};
        e.parity_err = (dut == 1) && bad_par;
        e.frame_err  = bad_stop;
        for (int i = 0; i < bits.size(); i++) begin
            if (i == bits.size() - 1 && expect_it) model_push(dut, e);
            if (dut == 0) rx_a = bits[i];
            else rx_b = bits[i];
            tick(CPB);
        end
        if (dut == 0) rx_a = 1'b1;
        else rx_b = 1'b1;
    endtask

    task automatic random_frames(input int dut, input int n);
        logic [7:0] d;
        bit bp, bs;
        for (int k = 0; k < n; k++) begin
            d  = 8'($urandom);
            bp = (dut == 1) && ($urandom_range(3, 0) == 0);
            bs = ($urandom_range(3, 0) == 0);
            send_frame(dut, d, bp, bs, 1'b1);
            tick($urandom_range(40, 20));
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_data"},  int'(data_a), 0);
        check({tag, "_valid"}, int'(valid_a), 0);
        check({tag, "_perr"},  int'(perr_a), 0);
        check({tag, "_ferr"},  int'(ferr_a), 0);
        check({tag, "_ovr"},   int'(ovr_a), 0);
        check({tag, "_busy"},  int'(busy_a), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] d;
        rst = 1'b1; rx_en = 1'b1; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
        tick(3);
        check_reset_a("reset");
        check("reset_valid_b", int'(valid_b), 0);
        check("reset_busy_b", int'(busy_b), 0);
        rst = 1'b0;
        tick(20);

        send_frame(0, 8'hB5, 1'b0, 1'b0, 1'b1);
        tick(30);
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1);
        tick(30);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
        tick(30);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        tick(30);

        fork
            random_frames(0, 8);
            random_frames(1, 8);
        join

        // Glitch: line low for 3 cycles only.
        rx_a = 1'b0;
        tick(2);
        check("glitch_busy_early", int'(busy_a), 0);
        tick(1);
        check("glitch_busy_rise", int'(busy_a), 1);
        rx_a = 1'b1;
        n = 0;
        while (busy_a && n < 12) begin
            tick(1);
            n++;
        end
        check("glitch_busy_fall", int'(busy_a), 0);
        check("glitch_within_10", int'(n <= 7), 1);
        tick(30);
        check("glitch_idle", int'(busy_a), 0);

        rx_en = 1'b0;
        send_frame(0, 8'h66, 1'b0, 1'b0, 1'b0);
        tick(30);
        rx_en = 1'b1;

        fork
            send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
            begin
                tick(40);
                rx_en = 1'b0;
            end
        join
        rx_en = 1'b1;
        tick(30);

        ready_a = 1'b0;
        for (int v = 1; v <= 5; v++) send_frame(0, 8'(v), 1'b0, 1'b0, 1'b1);
        tick(20);
        check("overrun_pulses", seen_ovr_a, exp_ovr_a);
        ready_a = 1'b1;
        tick(20);
        check("overrun_drained", q_a.size(), 0);

        // Reset during data bit 3 of an aborted frame.
        d = 8'hC6;
        rx_a = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_a = d[i];
            tick((i < 3) ? CPB : 5);
        end
        rst = 1'b1;
        rx_a = 1'b1;
        tick(1);
        check_reset_a("midreset");
        rst = 1'b0;
        tick(30);
        send_frame(0, 8'hA7, 1'b0, 1'b0, 1'b1);
        tick(50);

        check("final_queue_a", q_a.size(), 0);
        check("final_queue_b", q_b.size(), 0);
        check("final_overrun_a", seen_ovr_a, exp_ovr_a);
        check("final_overrun_b", seen_ovr_b, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
